dma_line_responder: RTL and testbench

Memory-side responder for the accelerator's 256-bit DMA read port. Accepts one line-read request at a time, fetches the eight 32-bit words of the 32-byte-aligned line from a 32-bit memory port, pipelining up to eight outstanding word reads. Assembles them into a 256-bit line and returns it with a single-cycle response strobe. Sits between the matmul accelerator's DMA master port and the shared data-memory arbiter; the CPU keeps priority on that arbiter via `mem_gnt`.

---
 rtl/dma_line_responder.sv | 119 +++++++++++
 tb/tb_dma_line_responder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_line_responder.sv
// Purpose: fetches one 32-byte line as eight 32-bit word reads and returns it as a 256-bit line.
// Latency: 10 cycles accept-to-response at best (grant every cycle, 1-cycle read latency); one line per 11 cycles peak.
// Backpressure: dma_req_ready only in IDLE, mem_re held until mem_gnt; the response is a one-cycle strobe with no ready.
//
// Ports:
//   clk, reset                   single clock, synchronous active-high reset
//   dma_addr/dma_re/dma_req_ready line read request (addr[4:0] ignored)
//   dma_resp_valid/dma_rdata     one-cycle response strobe with the assembled line (word i at [32*i+31:32*i])
//   mem_addr/mem_re/mem_gnt      word read request towards the shared memory arbiter
//   mem_rvalid/mem_rdata         in-order word read data, at least one cycle after grant
//   busy                         high whenever a line is in flight
//   err                          sticky flag: read data arrived with no read outstanding
module dma_line_responder (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  dma_addr,
  input  logic         dma_re,
  output logic         dma_req_ready,
  output logic         dma_resp_valid,
  output logic [255:0] dma_rdata,
  output logic [31:0]  mem_addr,
  output logic         mem_re,
  input  logic         mem_gnt,
  input  logic         mem_rvalid,
  input  logic [31:0]  mem_rdata,
  output logic         busy,
  output logic         err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [31:0]    base_q, base_d;
  logic [3:0]     issue_cnt_q, issue_cnt_d;
  logic [3:0]     ret_cnt_q, ret_cnt_d;
  logic [255:0]   line_q, line_d;
  logic           err_q, err_d;
  logic           rd_ok;

  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    issue_cnt_d    = issue_cnt_q;
    ret_cnt_d      = ret_cnt_q;
    line_d         = line_q;
    err_d          = err_q;
    dma_req_ready  = 1'b0;
    dma_resp_valid = 1'b0;
    mem_re         = 1'b0;
    mem_addr       = 32'd0;
    // A returning word is only legal while some issued read has not yet come back.
    rd_ok          = (state_q == ST_FETCH) && (ret_cnt_q != issue_cnt_q);

    case (state_q)
      ST_IDLE: begin
        dma_req_ready = 1'b1;
        if (dma_re) begin
          base_d      = dma_addr & 32'hFFFF_FFE0;
          issue_cnt_d = 4'd0;
          ret_cnt_d   = 4'd0;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_re   = (issue_cnt_q < 4'd8);
        // Line is 32-byte aligned, so the word offset never carries past bit 4.
        mem_addr = base_q + {27'd0, issue_cnt_q[2:0], 2'b00};
        if (mem_re && mem_gnt) begin
          issue_cnt_d = issue_cnt_q + 4'd1;
        end
        if (mem_rvalid && rd_ok) begin
          line_d[{ret_cnt_q[2:0], 5'b00000} +: 32] = mem_rdata;
          ret_cnt_d = ret_cnt_q + 4'd1;
          if (ret_cnt_q == 4'd7) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        dma_resp_valid = 1'b1;
        state_d        = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (mem_rvalid && !rd_ok) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      base_q      <= 32'd0;
      issue_cnt_q <= 4'd0;
      ret_cnt_q   <= 4'd0;
      line_q      <= 256'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      line_q      <= line_d;
      err_q       <= err_d;
    end
  end

  assign dma_rdata = line_q;
  assign busy      = (state_q != ST_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_dma_line_responder.sv
// Purpose: directed bench for dma_line_responder with a behavioural in-order memory.
// Latency: memory answers 1 cycle after grant, or 1-5 cycles (kept in order) in the random phase.
// Backpressure: memory grant is always 1, or random at 50% in the random phase.
module tb_dma_line_responder;

  logic         clk;
  logic         reset;
  logic [31:0]  dma_addr;
  logic         dma_re;
  logic         dma_req_ready;
  logic         dma_resp_valid;
  logic [255:0] dma_rdata;
  logic [31:0]  mem_addr;
  logic         mem_re;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;
  logic         busy;
  logic         err;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  logic        rnd_gnt = 1'b0;
  logic        rnd_lat = 1'b0;
  logic        spur    = 1'b0;

  logic [31:0]  gaddr[$];
  int           resp_cnt  = 0;
  int unsigned  resp_cyc  = 0;
  logic [255:0] last_line = '0;

  logic [31:0]  q_addr[$];
  int unsigned  q_due[$];

  dma_line_responder dut (
    .clk            (clk),
    .reset          (reset),
    .dma_addr       (dma_addr),
    .dma_re         (dma_re),
    .dma_req_ready  (dma_req_ready),
    .dma_resp_valid (dma_resp_valid),
    .dma_rdata      (dma_rdata),
    .mem_addr       (mem_addr),
    .mem_re         (mem_re),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .busy           (busy),
    .err            (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Passive recorder: grant addresses and response lines, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_re && mem_gnt) gaddr.push_back(mem_addr);
    if (dma_resp_valid) begin
      resp_cnt  = resp_cnt + 1;
      resp_cyc  = cyc;
      last_line = dma_rdata;
    end
  end

  // Memory model: word at byte address A holds A ^ 0xA5A50000, in-order responses.
  initial begin
    int unsigned due;
    logic [31:0] ra;
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      if (reset) begin
        q_addr.delete();
        q_due.delete();
      end else if (mem_re && mem_gnt) begin
        due = cyc + (rnd_lat ? $urandom_range(1, 5) : 1);
        if (q_due.size() > 0 && due <= q_due[$]) due = q_due[$] + 1;
        q_addr.push_back(mem_addr);
        q_due.push_back(due);
      end
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;
      if (spur) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
      end else if (q_due.size() > 0 && q_due[0] <= cyc) begin
        ra = q_addr.pop_front();
        void'(q_due.pop_front());
        mem_rvalid = 1'b1;
        mem_rdata  = ra ^ 32'hA5A5_0000;
      end
      mem_gnt = rnd_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [255:0] exp_line(input logic [31:0] a);
    logic [255:0] l;
    logic [31:0]  b;
    b = a & 32'hFFFF_FFE0;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = (b + 32'(4 * i)) ^ 32'hA5A5_0000;
    return l;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_ready(output int unsigned acc);
    bit ok;
    ok  = 1'b0;
    acc = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      #1;
      if (dma_req_ready) begin
        ok  = 1'b1;
        acc = cyc;
        break;
      end
    end
    chk("accept_timeout", 256'(ok), 256'd1);
  endtask

  task automatic do_req(input logic [31:0] a, output int unsigned acc);
    @(posedge clk);
    #1;
    dma_re   = 1'b1;
    dma_addr = a;
    wait_ready(acc);
    @(posedge clk);
    #1;
    dma_re = 1'b0;
  endtask

  task automatic wait_resp(input int r0);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      #1;
      chk("ready_low_while_busy", 256'(dma_req_ready), 256'd0);
      if (resp_cnt > r0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("resp_timeout", 256'(ok), 256'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},  256'(dma_req_ready),  256'd1);
    chk({tag, "_rvalid"}, 256'(dma_resp_valid), 256'd0);
    chk({tag, "_rdata"},  dma_rdata,            256'd0);
    chk({tag, "_mem_re"}, 256'(mem_re),         256'd0);
    chk({tag, "_maddr"},  256'(mem_addr),       256'd0);
    chk({tag, "_busy"},   256'(busy),           256'd0);
    chk({tag, "_err"},    256'(err),            256'd0);
  endtask

  initial begin
    int unsigned  acc, acc2, prev_resp;
    int           r0, g0, rstart;
    bit           ok;
    logic [31:0]  a;
    logic [255:0] l;

    reset    = 1'b1;
    dma_re   = 1'b0;
    dma_addr = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk_reset_vals("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Basic line read, grant always high, 1-cycle read latency.
    r0 = resp_cnt;
    g0 = gaddr.size();
    do_req(32'h0000_1040, acc);
    wait_resp(r0);
    chk("basic_latency", 256'(resp_cyc - acc), 256'd10);
    chk("basic_gnt_count", 256'(gaddr.size() - g0), 256'd8);
    for (int i = 0; i < 8; i++) chk("basic_mem_addr", 256'(gaddr[g0 + i]), 256'(32'h1040 + 4 * i));
    chk("basic_word0", 256'(last_line[31:0]), 256'h0A5A5_1040);
    chk("basic_word7", 256'(last_line[255:224]), 256'h0A5A5_105C);
    @(negedge clk);
    #1;
    chk("basic_ready_again", 256'(dma_req_ready), 256'd1);
    chk("basic_resp_single", 256'(dma_resp_valid), 256'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("basic_resp_count", 256'(resp_cnt - r0), 256'd1);

    // Unaligned address at the top of memory.
    r0 = resp_cnt;
    g0 = gaddr.size();
    do_req(32'hFFFF_FFFB, acc);
    wait_resp(r0);
    chk("top_first_addr", 256'(gaddr[g0]), 256'h0FFFF_FFE0);
    chk("top_last_addr", 256'(gaddr[g0 + 7]), 256'h0FFFF_FFFC);
    chk("top_line", last_line, exp_line(32'hFFFF_FFFB));
    chk("top_latency", 256'(resp_cyc - acc), 256'd10);

    // Request held high with a new address while the first line is in flight.
    r0 = resp_cnt;
    @(posedge clk);
    #1;
    dma_re   = 1'b1;
    dma_addr = 32'h0000_2000;
    wait_ready(acc);
    @(posedge clk);
    #1;
    dma_addr = 32'h0000_3060;
    ok   = 1'b0;
    acc2 = 0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      #1;
      if (dma_req_ready) begin
        ok   = 1'b1;
        acc2 = cyc;
        break;
      end
    end
    chk("busy_second_seen", 256'(ok), 256'd1);
    chk("busy_first_count", 256'(resp_cnt - r0), 256'd1);
    chk("busy_second_accept_cycle", 256'(acc2), 256'(resp_cyc + 1));
    chk("busy_first_latency", 256'(resp_cyc - acc), 256'd10);
    chk("busy_first_line", last_line, exp_line(32'h0000_2000));
    @(posedge clk);
    #1;
    dma_re = 1'b0;
    wait_resp(r0 + 1);
    chk("busy_second_line", last_line, exp_line(32'h0000_3060));
    chk("busy_second_latency", 256'(resp_cyc - acc2), 256'd10);
    repeat (15) @(negedge clk);
    #1;
    chk("busy_resp_total", 256'(resp_cnt - r0), 256'd2);

    // Spurious read data while idle.
    chk("spur_err_before", 256'(err), 256'd0);
    @(negedge clk);
    #1;
    spur = 1'b1;
    @(posedge clk);
    #2;
    spur = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("spur_err_set", 256'(err), 256'd1);
    chk("spur_rdata_kept", dma_rdata, exp_line(32'h0000_3060));
    r0 = resp_cnt;
    do_req(32'h0000_4080, acc);
    wait_resp(r0);
    chk("spur_next_line", last_line, exp_line(32'h0000_4080));
    chk("spur_err_sticky", 256'(err), 256'd1);

    // Reset after three words of a fetch have returned.
    r0 = resp_cnt;
    do_req(32'h0000_5000, acc);
    while (cyc < acc + 5) begin
      @(posedge clk);
      #1;
    end
    l = exp_line(32'h0000_5000);
    chk("rst_three_words", 256'(dma_rdata[95:0]), 256'(l[95:0]));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk_reset_vals("midreset");
    chk("midreset_no_resp", 256'(resp_cnt - r0), 256'd0);
    do_req(32'h0000_6020, acc);
    wait_resp(r0);
    chk("after_reset_latency", 256'(resp_cyc - acc), 256'd10);
    chk("after_reset_line", last_line, exp_line(32'h0000_6020));

    // Random grant backpressure and random in-order read latency, back-to-back.
    rnd_gnt   = 1'b1;
    rnd_lat   = 1'b1;
    rstart    = resp_cnt;
    prev_resp = 0;
    for (int k = 0; k < 100; k++) begin
      a  = $urandom;
      r0 = resp_cnt;
      g0 = gaddr.size();
      do_req(a, acc);
      if (k > 0) chk("rnd_back_to_back", 256'(acc), 256'(prev_resp + 1));
      wait_resp(r0);
      chk("rnd_line", last_line, exp_line(a));
      chk("rnd_gnt_count", 256'(gaddr.size() - g0), 256'd8);
      prev_resp = resp_cyc;
    end
    repeat (10) @(negedge clk);
    #1;
    chk("rnd_resp_total", 256'(resp_cnt - rstart), 256'd100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
